rbm_phase_ctrl: RTL and testbench
=================================

Name: rbm_phase_ctrl

Overview:
- Phase sequencer for one CD-1 training run of the RBM layer.
- Generates the 3-bit statesignal consumed by addr_gen and t_mem.
- Counts weight-load and update rows, gates en_fetch from the addr_gen FIFO status, and steers addr_fetch onto the t_mem v_addr/h_addr ports.
- Replaces the hand-driven phase stimulus and glue logic; runs a programmable number of iterations per start.

Parameters:
- N_ROWS, 3: rows of t_mem; load/update counters run 0..N_ROWS-1.
- ADDR_W, 2: width of row/neuron addresses.
- SAMPLE_CYC, 3: dwell cycles in each sample phase (addr_gen FIFO fill time).
- MAX_FETCH, 8: maximum cycles in a fetch phase before timeout.
- ITER_W, 4: width of cfg_iters.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; 0 freezes state and counters.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE.
- skip_load  in  1  sampled with start; 1 bypasses LOAD.
- cfg_iters  in  ITER_W  iterations per run; sampled with start; 0 is treated as 1.
- fifo_empty  in  1  addr_gen empty_fifo.
- addr_fetch  in  ADDR_W  addr_gen fetched neuron index.
- statesignal  out  3  current phase code (registered).
- en_fetch  out  1  pop request to addr_gen.
- v_addr  out  ADDR_W  t_mem visible-side address.
- h_addr  out  ADDR_W  t_mem hidden-side address.
- wr_en  out  1  t_mem weight write strobe in LOAD.
- upd_en  out  1  weight update strobe in UPD.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal completion.
- err_timeout  out  1  sticky; set when a fetch phase exceeds MAX_FETCH cycles.

Behaviour:
- Phase codes: IDLE=000, LOAD=001, FWD=010, BWD=011, UPD=100, SAMP_V=101, DONE=110, SAMP_H=111. statesignal always equals the current state register.
- Reset:
  - State is IDLE. All counters are 0.
  - statesignal=000.
  - wr_en, upd_en, en_fetch, busy, done, err_timeout are 0.
  - v_addr and h_addr are 0.
- Reset mid-run returns to IDLE on the next edge. No partial cleanup is performed.
- en=0 holds state and all counters. en_fetch, wr_en, upd_en and done are forced 0. Addresses hold their values.
- Run sequence:
  - IDLE: start&en latches cfg_iters (0→1), clears the iteration counter and clears err_timeout. Next state is LOAD, or SAMP_V if skip_load=1. start in any other state is ignored.
  - LOAD: lasts N_ROWS cycles. wr_en=1. h_addr=row counter 0,1,..,N_ROWS-1. Next state is SAMP_V.
  - SAMP_V: lasts SAMPLE_CYC cycles. Next state is FWD.
  - FWD:
    - en_fetch = en & !fifo_empty; v_addr=addr_fetch.
    - Exits to SAMP_H on the first cycle with fifo_empty=1. An empty FIFO at entry gives a 1-cycle dwell with no pops.
  - SAMP_H: lasts SAMPLE_CYC cycles. Next state is BWD.
  - BWD: en_fetch = en & !fifo_empty; h_addr=addr_fetch. Exits to UPD on fifo_empty=1, same rule as FWD.
  - UPD:
    - Lasts N_ROWS cycles. upd_en=1. h_addr=row counter.
    - At the last row the iteration counter increments. If it reaches cfg_iters the next state is DONE, else SAMP_V.
  - DONE: lasts 1 cycle. done=1. Next state is IDLE.
- Timeout:
  - FWD and BWD each count dwell cycles from 0 at phase entry.
  - If the count reaches MAX_FETCH with fifo_empty still 0: err_timeout is set, en_fetch is 0 that cycle, next state is IDLE, and done is not pulsed.
- Address outputs not driven by the current phase are 0. v_addr is nonzero only in FWD.
- Output timing: statesignal and the counters are registered. en_fetch, v_addr, h_addr, wr_en, upd_en and done are combinational from state, counters and inputs, with zero latency to addr_gen and t_mem.
- Arithmetic and widths: row counter is ADDR_W bits; N_ROWS ≤ 2^ADDR_W. Dwell counter is clog2(MAX_FETCH+1) bits. Iteration counter is ITER_W bits and never wraps, because the exit compare occurs first.

Decomposition:
- Package rbm_pkg: phase_t enum with the codes above (shared with addr_gen and t_mem) and the phase-code localparams.
- Sub-module phase_timer: a loadable down-counter with a zero flag, used for the LOAD, SAMP and UPD dwells. Fetch dwell counting stays in the top module.

Test Plan:
1. Reset, then start with skip_load=0, cfg_iters=1, fifo_empty toggled to allow 2 pops in FWD and 1 in BWD → statesignal sequence 001×3, 101×3, 010×3, 111×3, 011×2, 100×3, 110×1, 000; wr_en h_addr 0,1,2; done high 1 cycle.
2. skip_load=1, cfg_iters=0, fifo_empty=1 throughout → LOAD skipped; FWD and BWD 1 cycle each with en_fetch=0; one iteration; done pulses.
3. cfg_iters=3 → UPD is followed by SAMP_V twice, and DONE occurs after the third UPD; upd_en asserted for 9 cycles in total.
4. fifo_empty held 0 in FWD → after 8 cycles err_timeout=1, state=IDLE, done never pulses; the next start clears err_timeout.
5. en=0 for 4 cycles mid-LOAD at h_addr=1 → state and h_addr hold, wr_en=0; on resume LOAD completes with h_addr 1,2.
6. rst during BWD, and start asserted while busy → IDLE next cycle with all outputs at reset values; start while busy has no effect on the sequence.

Source files
------------

// File: rtl/rbm_pkg.sv
// rbm_pkg: phase codes shared by the RBM phase controller, addr_gen and t_mem
package rbm_pkg;
  localparam logic [2:0] PH_IDLE   = 3'b000;
  localparam logic [2:0] PH_LOAD   = 3'b001;
  localparam logic [2:0] PH_FWD    = 3'b010;
  localparam logic [2:0] PH_BWD    = 3'b011;
  localparam logic [2:0] PH_UPD    = 3'b100;
  localparam logic [2:0] PH_SAMP_V = 3'b101;
  localparam logic [2:0] PH_DONE   = 3'b110;
  localparam logic [2:0] PH_SAMP_H = 3'b111;
  typedef enum logic [2:0] {
    ST_IDLE   = PH_IDLE,
    ST_LOAD   = PH_LOAD,
    ST_FWD    = PH_FWD,
    ST_BWD    = PH_BWD,
    ST_UPD    = PH_UPD,
    ST_SAMP_V = PH_SAMP_V,
    ST_DONE   = PH_DONE,
    ST_SAMP_H = PH_SAMP_H
  } phase_t;
  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/rbm_phase_ctrl_if.sv
// rbm_phase_ctrl_if: control, addr_gen and t_mem signals of the phase controller
interface rbm_phase_ctrl_if #(
  parameter int ADDR_W = 2,
  parameter int ITER_W = 4
);
  logic              en;
  logic              start;
  logic              skip_load;
  logic [ITER_W-1:0] cfg_iters;
  logic              fifo_empty;
  logic [ADDR_W-1:0] addr_fetch;
  logic [2:0]        statesignal;
  logic              en_fetch;
  logic [ADDR_W-1:0] v_addr;
  logic [ADDR_W-1:0] h_addr;
  logic              wr_en;
  logic              upd_en;
  logic              busy;
  logic              done;
  logic              err_timeout;
  modport master (
    input  en, start, skip_load, cfg_iters, fifo_empty, addr_fetch,
    output statesignal, en_fetch, v_addr, h_addr, wr_en, upd_en, busy, done, err_timeout
  );
  modport slave (
    output en, start, skip_load, cfg_iters, fifo_empty, addr_fetch,
    input  statesignal, en_fetch, v_addr, h_addr, wr_en, upd_en, busy, done, err_timeout
  );
endinterface

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter with zero flag for fixed-length phase dwells
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  // load wins; otherwise count down to zero and stick there
  always_comb begin
    cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    zero  = cnt_q == '0;
  end
  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rbm_phase_ctrl.sv
// rbm_phase_ctrl: CD-1 phase sequencer driving addr_gen and t_mem for a run of iterations
module rbm_phase_ctrl
  import rbm_pkg::*;
#(
  parameter int N_ROWS     = 3,
  parameter int ADDR_W     = 2,
  parameter int SAMPLE_CYC = 3,
  parameter int MAX_FETCH  = 8,
  parameter int ITER_W     = 4
) (
  input logic clk,
  input logic rst,
  rbm_phase_ctrl_if.master bus
);
  localparam int FW = $clog2(MAX_FETCH + 1);
  localparam int TW = $clog2(imax(N_ROWS, SAMPLE_CYC) + 1);
  localparam logic [TW-1:0] T_ROWS = TW'(N_ROWS - 1);
  localparam logic [TW-1:0] T_SAMP = TW'(SAMPLE_CYC - 1);
  phase_t            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [ITER_W-1:0] iter_q, iter_d, iters_q, iters_d;
  logic              err_q, err_d;
  logic              t_load, t_zero;
  logic [TW-1:0]     t_val;
  logic              fetch, timeout;
  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );
  // next-state and counter updates; everything holds while en is low
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    fcnt_d  = fcnt_q;
    iter_d  = iter_q;
    iters_d = iters_q;
    err_d   = err_q;
    t_load  = 1'b0;
    t_val   = '0;
    fetch   = state_q == ST_FWD || state_q == ST_BWD;
    timeout = fetch && !bus.fifo_empty && fcnt_q == FW'(MAX_FETCH);
    if (bus.en) begin
      case (state_q)
        ST_IDLE: if (bus.start) begin
          iters_d = bus.cfg_iters == '0 ? ITER_W'(1) : bus.cfg_iters;
          iter_d  = '0;
          err_d   = 1'b0;
          row_d   = '0;
          t_load  = 1'b1;
          t_val   = bus.skip_load ? T_SAMP : T_ROWS;
          state_d = bus.skip_load ? ST_SAMP_V : ST_LOAD;
        end
        ST_LOAD: if (t_zero) begin
          state_d = ST_SAMP_V;
          row_d   = '0;
          t_load  = 1'b1;
          t_val   = T_SAMP;
        end else row_d = row_q + ADDR_W'(1);
        ST_SAMP_V: if (t_zero) begin
          state_d = ST_FWD;
          fcnt_d  = '0;
        end
        ST_FWD: if (bus.fifo_empty) begin
          state_d = ST_SAMP_H;
          t_load  = 1'b1;
          t_val   = T_SAMP;
        end else if (timeout) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else fcnt_d = fcnt_q + FW'(1);
        ST_SAMP_H: if (t_zero) begin
          state_d = ST_BWD;
          fcnt_d  = '0;
        end
        ST_BWD: if (bus.fifo_empty) begin
          state_d = ST_UPD;
          row_d   = '0;
          t_load  = 1'b1;
          t_val   = T_ROWS;
        end else if (timeout) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else fcnt_d = fcnt_q + FW'(1);
        ST_UPD: if (t_zero) begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = iter_q + ITER_W'(1) == iters_q ? ST_DONE : ST_SAMP_V;
          row_d   = '0;
          t_load  = 1'b1;
          t_val   = T_SAMP;
        end else row_d = row_q + ADDR_W'(1);
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end
  // zero-latency strobes and address steering toward addr_gen and t_mem
  always_comb begin
    bus.statesignal = state_q;
    bus.busy        = state_q != ST_IDLE;
    bus.err_timeout = err_q;
    bus.done        = bus.en && state_q == ST_DONE;
    bus.wr_en       = bus.en && state_q == ST_LOAD;
    bus.upd_en      = bus.en && state_q == ST_UPD;
    bus.en_fetch    = bus.en && fetch && !bus.fifo_empty && !timeout;
    bus.v_addr      = state_q == ST_FWD ? bus.addr_fetch : '0;
    bus.h_addr      = (state_q == ST_LOAD || state_q == ST_UPD) ? row_q :
                      state_q == ST_BWD ? bus.addr_fetch : '0;
  end
  // state, counter and sticky-error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      fcnt_q  <= '0;
      iter_q  <= '0;
      iters_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      fcnt_q  <= fcnt_d;
      iter_q  <= iter_d;
      iters_q <= iters_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_rbm_phase_ctrl.sv
// tb_rbm_phase_ctrl: scoreboard bench for the RBM phase controller
module tb_rbm_phase_ctrl;
  import rbm_pkg::*;
  logic clk, rst;
  int n_run, n_fail, upd_seen;
  logic [12:0] sb[$];
  rbm_phase_ctrl_if #(.ADDR_W(2), .ITER_W(4)) bus ();
  rbm_phase_ctrl #(
    .N_ROWS(3), .ADDR_W(2), .SAMPLE_CYC(3), .MAX_FETCH(8), .ITER_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [12:0] ex(input logic [2:0] st, input logic wr, upd, ef, dn, err,
                                     input logic [1:0] ha, va);
    return {st, st != PH_IDLE, wr, upd, ef, dn, err, ha, va};
  endfunction
  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (st,busy,wr,upd,ef,dn,err,ha,va)", tag, got, exp);
    end
  endtask
  task automatic drive(input string tag, input logic fe, input logic [1:0] af, input logic [12:0] e);
    logic [12:0] got, want;
    bus.fifo_empty = fe;
    bus.addr_fetch = af;
    sb.push_back(e);
    @(negedge clk);
    got = {bus.statesignal, bus.busy, bus.wr_en, bus.upd_en, bus.en_fetch, bus.done,
           bus.err_timeout, bus.h_addr, bus.v_addr};
    if (bus.upd_en) upd_seen++;
    want = sb.pop_front();
    chk(tag, got, want);
    @(posedge clk);
    #1;
  endtask
  task automatic samp(input string tag, input logic [2:0] ph, input logic err);
    for (int i = 0; i < 3; i++) drive(tag, 1'b0, 2'd3, ex(ph, 0, 0, 0, 0, err, 2'd0, 2'd0));
  endtask
  task automatic go(input logic skip, input logic [3:0] iters, input logic err);
    bus.start = 1'b1;
    bus.skip_load = skip;
    bus.cfg_iters = iters;
    drive("start_idle", 1'b1, 2'd0, ex(PH_IDLE, 0, 0, 0, 0, err, 2'd0, 2'd0));
    bus.start = 1'b0;
    bus.cfg_iters = 4'd0;
  endtask
  initial begin
    n_run = 0;
    n_fail = 0;
    upd_seen = 0;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.start = 1'b0;
    bus.skip_load = 1'b0;
    bus.cfg_iters = 4'd0;
    bus.fifo_empty = 1'b1;
    bus.addr_fetch = 2'd0;
    @(posedge clk);
    #1;
    drive("reset", 1'b0, 2'd3, ex(PH_IDLE, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    rst = 1'b0;
    drive("idle", 1'b0, 2'd3, ex(PH_IDLE, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    go(1'b0, 4'd1, 1'b0);
    for (int i = 0; i < 3; i++) drive("t1_load", 1'b1, 2'd3, ex(PH_LOAD, 1, 0, 0, 0, 0, 2'(i), 2'd0));
    samp("t1_sampv", PH_SAMP_V, 1'b0);
    drive("t1_fwd0", 1'b0, 2'd2, ex(PH_FWD, 0, 0, 1, 0, 0, 2'd0, 2'd2));
    drive("t1_fwd1", 1'b0, 2'd1, ex(PH_FWD, 0, 0, 1, 0, 0, 2'd0, 2'd1));
    drive("t1_fwd2", 1'b1, 2'd3, ex(PH_FWD, 0, 0, 0, 0, 0, 2'd0, 2'd3));
    samp("t1_samph", PH_SAMP_H, 1'b0);
    drive("t1_bwd0", 1'b0, 2'd1, ex(PH_BWD, 0, 0, 1, 0, 0, 2'd1, 2'd0));
    drive("t1_bwd1", 1'b1, 2'd2, ex(PH_BWD, 0, 0, 0, 0, 0, 2'd2, 2'd0));
    for (int i = 0; i < 3; i++) drive("t1_upd", 1'b0, 2'd3, ex(PH_UPD, 0, 1, 0, 0, 0, 2'(i), 2'd0));
    drive("t1_done", 1'b0, 2'd3, ex(PH_DONE, 0, 0, 0, 1, 0, 2'd0, 2'd0));
    drive("t1_end", 1'b0, 2'd3, ex(PH_IDLE, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    go(1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) drive("t2_sampv", 1'b1, 2'd2, ex(PH_SAMP_V, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    drive("t2_fwd", 1'b1, 2'd2, ex(PH_FWD, 0, 0, 0, 0, 0, 2'd0, 2'd2));
    for (int i = 0; i < 3; i++) drive("t2_samph", 1'b1, 2'd2, ex(PH_SAMP_H, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    drive("t2_bwd", 1'b1, 2'd1, ex(PH_BWD, 0, 0, 0, 0, 0, 2'd1, 2'd0));
    for (int i = 0; i < 3; i++) drive("t2_upd", 1'b1, 2'd0, ex(PH_UPD, 0, 1, 0, 0, 0, 2'(i), 2'd0));
    drive("t2_done", 1'b1, 2'd0, ex(PH_DONE, 0, 0, 0, 1, 0, 2'd0, 2'd0));
    drive("t2_end", 1'b1, 2'd0, ex(PH_IDLE, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    upd_seen = 0;
    go(1'b1, 4'd3, 1'b0);
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 3; i++) drive("t3_sampv", 1'b1, 2'd0, ex(PH_SAMP_V, 0, 0, 0, 0, 0, 2'd0, 2'd0));
      drive("t3_fwd", 1'b1, 2'd0, ex(PH_FWD, 0, 0, 0, 0, 0, 2'd0, 2'd0));
      for (int i = 0; i < 3; i++) drive("t3_samph", 1'b1, 2'd0, ex(PH_SAMP_H, 0, 0, 0, 0, 0, 2'd0, 2'd0));
      drive("t3_bwd", 1'b1, 2'd0, ex(PH_BWD, 0, 0, 0, 0, 0, 2'd0, 2'd0));
      for (int i = 0; i < 3; i++) drive("t3_upd", 1'b1, 2'd0, ex(PH_UPD, 0, 1, 0, 0, 0, 2'(i), 2'd0));
    end
    drive("t3_done", 1'b1, 2'd0, ex(PH_DONE, 0, 0, 0, 1, 0, 2'd0, 2'd0));
    chk("t3_upd_cycles", 13'(upd_seen), 13'd9);
    drive("t3_end", 1'b1, 2'd0, ex(PH_IDLE, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    go(1'b1, 4'd1, 1'b0);
    samp("t4_sampv", PH_SAMP_V, 1'b0);
    for (int i = 0; i < 8; i++) drive("t4_fwd_pop", 1'b0, 2'd1, ex(PH_FWD, 0, 0, 1, 0, 0, 2'd0, 2'd1));
    drive("t4_fwd_tmo", 1'b0, 2'd1, ex(PH_FWD, 0, 0, 0, 0, 0, 2'd0, 2'd1));
    for (int i = 0; i < 2; i++) drive("t4_idle_err", 1'b0, 2'd1, ex(PH_IDLE, 0, 0, 0, 0, 1, 2'd0, 2'd0));
    go(1'b0, 4'd1, 1'b1);
    drive("t5_load0", 1'b1, 2'd0, ex(PH_LOAD, 1, 0, 0, 0, 0, 2'd0, 2'd0));
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) drive("t5_hold", 1'b1, 2'd0, ex(PH_LOAD, 0, 0, 0, 0, 0, 2'd1, 2'd0));
    bus.en = 1'b1;
    drive("t5_load1", 1'b1, 2'd0, ex(PH_LOAD, 1, 0, 0, 0, 0, 2'd1, 2'd0));
    drive("t5_load2", 1'b1, 2'd0, ex(PH_LOAD, 1, 0, 0, 0, 0, 2'd2, 2'd0));
    bus.start = 1'b1;
    samp("t6_sampv", PH_SAMP_V, 1'b0);
    drive("t6_fwd0", 1'b0, 2'd1, ex(PH_FWD, 0, 0, 1, 0, 0, 2'd0, 2'd1));
    drive("t6_fwd1", 1'b1, 2'd0, ex(PH_FWD, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    samp("t6_samph", PH_SAMP_H, 1'b0);
    drive("t6_bwd0", 1'b0, 2'd2, ex(PH_BWD, 0, 0, 1, 0, 0, 2'd2, 2'd0));
    rst = 1'b1;
    drive("t6_bwd_rst", 1'b0, 2'd2, ex(PH_BWD, 0, 0, 1, 0, 0, 2'd2, 2'd0));
    rst = 1'b0;
    bus.start = 1'b0;
    drive("t6_after_rst", 1'b0, 2'd3, ex(PH_IDLE, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    drive("t6_idle", 1'b0, 2'd3, ex(PH_IDLE, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
